// File: rtl/exec_alu_unit_pkg.sv
// Shared encodings for the execute-stage ALU: control codes, shift selectors
// and the iterative-shift FSM states.
package exec_alu_unit_pkg;

  localparam logic [2:0] ALU_CTL_ADD      = 3'd0;
  localparam logic [2:0] ALU_CTL_SUB      = 3'd1;
  localparam logic [2:0] ALU_CTL_AND      = 3'd2;
  localparam logic [2:0] ALU_CTL_OR       = 3'd3;
  localparam logic [2:0] ALU_CTL_XOR      = 3'd4;
  localparam logic [2:0] ALU_CTL_LESS_SIG = 3'd5;
  localparam logic [2:0] ALU_CTL_LESS_UNS = 3'd6;
  localparam logic [2:0] ALU_CTL_SHIFT    = 3'd7;

  localparam logic [1:0] ALU_SHIFT_SLL  = 2'd0;
  localparam logic [1:0] ALU_SHIFT_SRL  = 2'd1;
  localparam logic [1:0] ALU_SHIFT_SRA  = 2'd2;
  localparam logic [1:0] ALU_SHIFT_NONE = 2'd3;

  localparam logic [0:0] EXU_S_IDLE  = 1'b0;
  localparam logic [0:0] EXU_S_SHIFT = 1'b1;

  // Only SLL/SRL/SRA start the iterative shifter; anything else passes op_a.
  function automatic logic is_real_shift(input logic [1:0] code);
    return (code == ALU_SHIFT_SLL) || (code == ALU_SHIFT_SRL) ||
           (code == ALU_SHIFT_SRA);
  endfunction

endpackage

// File: rtl/exec_alu_unit_comb.sv
// Combinational single-cycle ALU core; also reused by branch compare logic.
module alu_comb_core
  import exec_alu_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_ctl,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_result
);

  always_comb begin
    o_result = '0;
    case (i_ctl)
      ALU_CTL_ADD:      o_result = i_a + i_b;
      ALU_CTL_SUB:      o_result = i_a - i_b;
      ALU_CTL_AND:      o_result = i_a & i_b;
      ALU_CTL_OR:       o_result = i_a | i_b;
      ALU_CTL_XOR:      o_result = i_a ^ i_b;
      ALU_CTL_LESS_SIG: o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_CTL_LESS_UNS: o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      // Zero-distance or non-shift selector: the shift degenerates to op_a.
      ALU_CTL_SHIFT:    o_result = i_a;
      default:          o_result = '0;
    endcase
  end

endmodule

// File: rtl/exec_alu_unit.sv
// Execute-stage ALU: single-cycle ops via alu_comb_core, shifts on an
// iterative shifter moving up to SHIFT_STEP bits per cycle.
module exec_alu_unit
  import exec_alu_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_alu_ctl,
  input  logic [1:0]      i_alu_shift,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero,
  output logic            o_busy
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] STEP_C = CW'(SHIFT_STEP);

  logic [0:0]      r_state;
  logic [XLEN-1:0] r_work;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_mode;
  logic            r_valid;
  logic [XLEN-1:0] r_result;

  logic [XLEN-1:0] w_core_result;
  logic            w_slot_free;
  logic            w_accept;
  logic [SHW-1:0]  w_shamt;
  logic            w_shift_start;
  logic [CW-1:0]   w_step;
  logic [CW-1:0]   w_cnt_next;
  logic [XLEN-1:0] w_work_next;
  logic            w_shift_done;

  alu_comb_core #(.XLEN(XLEN)) u_core (
    .i_ctl    (i_alu_ctl),
    .i_a      (i_op_a),
    .i_b      (i_op_b),
    .o_result (w_core_result)
  );

  // Handshake: an operation transfers in when i_valid && o_ready at a rising
  // edge; a result transfers out when o_valid && i_ready at a rising edge.
  // o_valid/o_result stay stable until the result is taken.
  assign w_slot_free   = !r_valid || i_ready;
  assign o_ready       = (r_state == EXU_S_IDLE) && w_slot_free && !i_flush;
  assign w_accept      = i_valid && o_ready;
  assign w_shamt       = i_op_b[SHW-1:0];
  assign w_shift_start = w_accept && (i_alu_ctl == ALU_CTL_SHIFT) &&
                         (w_shamt != '0) && is_real_shift(i_alu_shift);

  assign w_step     = (r_cnt > STEP_C) ? STEP_C : r_cnt;
  assign w_cnt_next = r_cnt - w_step;

  always_comb begin
    w_work_next = r_work;
    case (r_mode)
      ALU_SHIFT_SLL: w_work_next = r_work << w_step;
      ALU_SHIFT_SRL: w_work_next = r_work >> w_step;
      ALU_SHIFT_SRA: w_work_next = $signed(r_work) >>> w_step;
      default:       w_work_next = r_work;
    endcase
  end

  // A finished shift waits in SHIFT with cnt=0 until the output slot frees.
  assign w_shift_done = (r_state == EXU_S_SHIFT) && (w_cnt_next == '0) && w_slot_free;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= EXU_S_IDLE;
      r_work   <= '0;
      r_cnt    <= '0;
      r_mode   <= ALU_SHIFT_SLL;
      r_valid  <= 1'b0;
      r_result <= '0;
    end else if (i_flush) begin
      r_state <= EXU_S_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_shift_start) begin
        r_state <= EXU_S_SHIFT;
        r_work  <= i_op_a;
        r_cnt   <= {1'b0, w_shamt};
        r_mode  <= i_alu_shift;
      end else if (r_state == EXU_S_SHIFT) begin
        r_work <= w_work_next;
        r_cnt  <= w_cnt_next;
        if (w_shift_done) r_state <= EXU_S_IDLE;
      end

      if (w_shift_done) begin
        r_result <= w_work_next;
        r_valid  <= 1'b1;
      end else if (w_accept && !w_shift_start) begin
        r_result <= w_core_result;
        r_valid  <= 1'b1;
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid  = r_valid;
  assign o_result = r_result;
  assign o_zero   = (r_result == '0);
  assign o_busy   = (r_state == EXU_S_SHIFT);

endmodule
